// File: rtl/fifo_arb_pkg.sv
// Shared constants for the FIFO write arbiter: state encoding and default sizing.
package fifo_arb_pkg;

    localparam int unsigned DEF_NUM_REQ         = 4;
    localparam int unsigned DEF_ID_WIDTH        = 2;
    localparam int unsigned DEF_DATA_WIDTH      = 4;
    localparam int unsigned DEF_BURST_LEN       = 4;
    localparam int unsigned DEF_BURST_CNT_WIDTH = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit scanning cyclically from last+1.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ  = DEF_NUM_REQ,
    parameter int unsigned ID_WIDTH = DEF_ID_WIDTH
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] last,
    output logic                found,
    output logic [ID_WIDTH-1:0] idx
);

    // Choose the requester with the smallest cyclic distance past the last grant.
    always_comb begin : pick
        int unsigned best_off;
        int unsigned off;
        found    = 1'b0;
        idx      = '0;
        best_off = NUM_REQ;
        off      = 0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            off = (j + 2 * NUM_REQ - 32'(last) - 1) % NUM_REQ;
            if (req[j] && (off < best_off)) begin
                best_off = off;
                idx      = ID_WIDTH'(j);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one FIFO enqueue port among NUM_REQ producers.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ         = DEF_NUM_REQ,
    parameter int unsigned ID_WIDTH        = DEF_ID_WIDTH,
    parameter int unsigned DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int unsigned BURST_LEN       = DEF_BURST_LEN,
    parameter int unsigned BURST_CNT_WIDTH = DEF_BURST_CNT_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clr_in,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0]             req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [ID_WIDTH+DATA_WIDTH-1:0] fifo_din,
    output logic                           fifo_enq,
    input  logic                           fifo_full_n,
    output logic                           fifo_clr,
    output logic [ID_WIDTH-1:0]            grant_id,
    output logic                           busy
);

    localparam logic [BURST_CNT_WIDTH-1:0] LAST_BEAT = BURST_CNT_WIDTH'(BURST_LEN - 1);

    arb_state_e                 state, state_nx;
    logic [ID_WIDTH-1:0]        owner, owner_nx;
    logic [ID_WIDTH-1:0]        last_grant, last_grant_nx;
    logic [BURST_CNT_WIDTH-1:0] beat_cnt, beat_cnt_nx;

    logic                       pick_found;
    logic [ID_WIDTH-1:0]        pick_idx;
    logic                       own_valid;
    logic                       own_last;
    logic [DATA_WIDTH-1:0]      own_data;
    logic                       live;
    logic                       transfer;

    // Reset is active-high here; outputs stay quiet while it is held.
    assign live = ~rst_n;

    rr_pick #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_rr_pick (
        .req   (req_valid),
        .last  (last_grant),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Select the current owner's valid/last/data lanes.
    always_comb begin
        own_valid = 1'b0;
        own_last  = 1'b0;
        own_data  = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (owner == ID_WIDTH'(j)) begin
                own_valid = req_valid[j];
                own_last  = req_last[j];
                own_data  = req_data[j*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next-state and handshake logic; clr_in overrides any transfer.
    always_comb begin
        state_nx      = state;
        owner_nx      = owner;
        last_grant_nx = last_grant;
        beat_cnt_nx   = beat_cnt;
        req_ready     = '0;
        fifo_enq      = 1'b0;
        transfer      = 1'b0;
        fifo_din      = {owner, own_data};
        fifo_clr      = clr_in & live;

        if (clr_in) begin
            state_nx    = IDLE;
            beat_cnt_nx = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        owner_nx      = pick_idx;
                        last_grant_nx = pick_idx;
                        beat_cnt_nx   = '0;
                        state_nx      = GRANT;
                    end
                end
                GRANT: begin
                    for (int unsigned j = 0; j < NUM_REQ; j++) begin
                        if (owner == ID_WIDTH'(j)) begin
                            req_ready[j] = fifo_full_n & live;
                        end
                    end
                    transfer = own_valid & fifo_full_n & live;
                    fifo_enq = transfer;
                    if (transfer) begin
                        if (own_last || (beat_cnt == LAST_BEAT)) begin
                            state_nx    = IDLE;
                            beat_cnt_nx = '0;
                        end else begin
                            beat_cnt_nx = beat_cnt + BURST_CNT_WIDTH'(1);
                        end
                    end
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state      <= IDLE;
            owner      <= '0;
            last_grant <= ID_WIDTH'(NUM_REQ - 1);
            beat_cnt   <= '0;
        end else begin
            state      <= state_nx;
            owner      <= owner_nx;
            last_grant <= last_grant_nx;
            beat_cnt   <= beat_cnt_nx;
        end
    end

    assign grant_id = owner;
    assign busy     = (state == GRANT);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a behavioural depth-3 FIFO model.
module tb_fifo_wr_arbiter;
    import fifo_arb_pkg::*;

    localparam int unsigned NR = DEF_NUM_REQ;
    localparam int unsigned IW = DEF_ID_WIDTH;
    localparam int unsigned DW = DEF_DATA_WIDTH;
    localparam int unsigned FW = IW + DW;
    localparam int          FIFO_DEPTH = 3;

    logic              clk;
    logic              rst_n;
    logic              clr_in;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_last;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic [FW-1:0]     fifo_din;
    logic              fifo_enq;
    logic              fifo_full_n;
    logic              fifo_clr;
    logic [IW-1:0]     grant_id;
    logic              busy;

    logic              fifo_deq;
    logic              fifo_empty_n;
    int                fifo_cnt;
    int                enq_total;
    logic [FW-1:0]     enq_log [0:63];

    int n_checks;
    int n_pass;

    fifo_wr_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_in      (clr_in),
        .req_valid   (req_valid),
        .req_last    (req_last),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .fifo_din    (fifo_din),
        .fifo_enq    (fifo_enq),
        .fifo_full_n (fifo_full_n),
        .fifo_clr    (fifo_clr),
        .grant_id    (grant_id),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign fifo_full_n  = (fifo_cnt < FIFO_DEPTH);
    assign fifo_empty_n = (fifo_cnt != 0);

    // Occupancy model of the shared FIFO plus a log of every enqueued word.
    always @(posedge clk) begin
        if (rst_n || fifo_clr) begin
            fifo_cnt <= 0;
        end else begin
            fifo_cnt <= fifo_cnt + ((fifo_enq && fifo_full_n) ? 1 : 0)
                                 - ((fifo_deq && fifo_cnt > 0) ? 1 : 0);
        end
        if (!rst_n && fifo_enq) begin
            if (enq_total < 64) enq_log[enq_total] <= fifo_din;
            enq_total <= enq_total + 1;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b1;
        clr_in    = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        fifo_deq  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n     = 1'b1;
        clr_in    = 1'b0;
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        req_data  = 16'h4321;
        fifo_deq  = 1'b0;
        @(negedge clk);
        #1;
        n_checks++; if (req_ready !== 4'b0000) $display("FAIL rst_ready: got %b exp 0000", req_ready); else n_pass++;
        n_checks++; if (fifo_enq !== 1'b0) $display("FAIL rst_enq: got %b exp 0", fifo_enq); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b exp 0", busy); else n_pass++;
        n_checks++; if (grant_id !== 2'd0) $display("FAIL rst_grant_id: got %0d exp 0", grant_id); else n_pass++;
        clr_in = 1'b1;
        #1;
        n_checks++; if (fifo_clr !== 1'b0) $display("FAIL rst_clr_forced: got %b exp 0", fifo_clr); else n_pass++;
        @(negedge clk);
        clr_in = 1'b0;
        rst_n  = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_release_idle: got %b exp 0", busy); else n_pass++;
        @(negedge clk);
        #1;
        n_checks++; if (busy !== 1'b1) $display("FAIL rst_first_busy: got %b exp 1", busy); else n_pass++;
        n_checks++; if (grant_id !== 2'd0) $display("FAIL rst_first_grant: got %0d exp 0", grant_id); else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [FW-1:0] exp_din [0:2];
        int base;
        exp_din = '{6'h01, 6'h12, 6'h23};
        do_reset();
        base      = enq_total;
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        req_data  = 16'h4321;
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL rr_start_idle: got %b exp 0", busy); else n_pass++;
        for (int g = 0; g < 3; g++) begin
            @(negedge clk);
            #1;
            n_checks++; if (grant_id !== IW'(g) || busy !== 1'b1) $display("FAIL rr_grant%0d: got id %0d busy %b exp id %0d busy 1", g, grant_id, busy, g); else n_pass++;
            n_checks++; if (fifo_enq !== 1'b1 || fifo_din !== exp_din[g]) $display("FAIL rr_din%0d: got enq %b din %h exp enq 1 din %h", g, fifo_enq, fifo_din, exp_din[g]); else n_pass++;
            n_checks++; if (req_ready !== NR'(1 << g)) $display("FAIL rr_ready%0d: got %b exp %b", g, req_ready, NR'(1 << g)); else n_pass++;
            @(negedge clk);
            #1;
            n_checks++; if (busy !== 1'b0) $display("FAIL rr_bubble%0d: got busy %b exp 0", g, busy); else n_pass++;
        end
        @(negedge clk);
        #1;
        n_checks++; if (grant_id !== 2'd3 || busy !== 1'b1) $display("FAIL rr_grant3: got id %0d busy %b exp id 3 busy 1", grant_id, busy); else n_pass++;
        n_checks++; if (fifo_full_n !== 1'b0 || fifo_enq !== 1'b0 || req_ready !== 4'b0000) $display("FAIL rr_full_stall: got full_n %b enq %b ready %b exp 0 0 0000", fifo_full_n, fifo_enq, req_ready); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (enq_log[base + k] !== exp_din[k]) $display("FAIL rr_log%0d: got %h exp %h", k, enq_log[base + k], exp_din[k]); else n_pass++;
        end
        fifo_deq = 1'b1;
        @(negedge clk);
        fifo_deq = 1'b0;
        #1;
        n_checks++; if (fifo_enq !== 1'b1 || fifo_din !== 6'h34 || req_ready !== 4'b1000) $display("FAIL rr_owner3_beat: got enq %b din %h ready %b exp 1 34 1000", fifo_enq, fifo_din, req_ready); else n_pass++;
        @(negedge clk);
        @(negedge clk);
        #1;
        n_checks++; if (grant_id !== 2'd0 || busy !== 1'b1) $display("FAIL rr_wrap0: got id %0d busy %b exp id 0 busy 1", grant_id, busy); else n_pass++;
    endtask

    task automatic test_burst_cap();
        logic          exp_busy [0:8];
        logic          exp_enq  [0:8];
        logic [FW-1:0] exp_din  [0:8];
        int beat;
        exp_busy = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        exp_enq  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        exp_din  = '{6'h00, 6'h11, 6'h12, 6'h13, 6'h14, 6'h00, 6'h15, 6'h16, 6'h00};
        do_reset();
        beat      = 1;
        req_valid = 4'b0010;
        req_last  = 4'b0000;
        fifo_deq  = 1'b1;
        for (int c = 0; c < 9; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 8) req_valid = 4'b0000;
            req_data = 16'(beat) << 4;
            #1;
            n_checks++; if (busy !== exp_busy[c] || fifo_enq !== exp_enq[c]) $display("FAIL burst_c%0d: got busy %b enq %b exp busy %b enq %b", c, busy, fifo_enq, exp_busy[c], exp_enq[c]); else n_pass++;
            if (exp_enq[c]) begin
                n_checks++; if (fifo_din !== exp_din[c]) $display("FAIL burst_din_c%0d: got %h exp %h", c, fifo_din, exp_din[c]); else n_pass++;
                beat++;
            end
        end
        fifo_deq = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        req_valid = 4'b0001;
        req_last  = 4'b0000;
        fifo_deq  = 1'b0;
        for (int b = 1; b <= 3; b++) begin
            @(negedge clk);
            req_data = 16'(b);
            #1;
            n_checks++; if (fifo_enq !== 1'b1 || fifo_din !== FW'(b)) $display("FAIL bp_beat%0d: got enq %b din %h exp enq 1 din %h", b, fifo_enq, fifo_din, FW'(b)); else n_pass++;
        end
        @(negedge clk);
        req_data = 16'h0004;
        req_last = 4'b0001;
        #1;
        n_checks++; if (fifo_full_n !== 1'b0 || req_ready !== 4'b0000 || fifo_enq !== 1'b0) $display("FAIL bp_stall: got full_n %b ready %b enq %b exp 0 0000 0", fifo_full_n, req_ready, fifo_enq); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL bp_hold_grant: got busy %b exp 1", busy); else n_pass++;
        fifo_deq = 1'b1;
        @(negedge clk);
        fifo_deq = 1'b0;
        #1;
        n_checks++; if (fifo_enq !== 1'b1 || fifo_din !== 6'h04 || req_ready !== 4'b0001) $display("FAIL bp_beat4: got enq %b din %h ready %b exp 1 04 0001", fifo_enq, fifo_din, req_ready); else n_pass++;
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL bp_idle: got busy %b exp 0", busy); else n_pass++;
    endtask

    task automatic test_flush();
        do_reset();
        req_valid = 4'b1100;
        req_last  = 4'b0000;
        req_data  = 16'h9500;
        fifo_deq  = 1'b0;
        @(negedge clk);
        #1;
        n_checks++; if (grant_id !== 2'd2 || fifo_enq !== 1'b1 || fifo_din !== 6'h25) $display("FAIL flush_beat1: got id %0d enq %b din %h exp 2 1 25", grant_id, fifo_enq, fifo_din); else n_pass++;
        @(negedge clk);
        #1;
        n_checks++; if (fifo_enq !== 1'b1) $display("FAIL flush_beat2: got enq %b exp 1", fifo_enq); else n_pass++;
        @(negedge clk);
        clr_in = 1'b1;
        #1;
        n_checks++; if (fifo_clr !== 1'b1 || fifo_enq !== 1'b0 || req_ready !== 4'b0000) $display("FAIL flush_cycle: got clr %b enq %b ready %b exp 1 0 0000", fifo_clr, fifo_enq, req_ready); else n_pass++;
        @(negedge clk);
        clr_in = 1'b0;
        #1;
        n_checks++; if (fifo_empty_n !== 1'b0 || busy !== 1'b0) $display("FAIL flush_after: got empty_n %b busy %b exp 0 0", fifo_empty_n, busy); else n_pass++;
        @(negedge clk);
        #1;
        n_checks++; if (grant_id !== 2'd3 || busy !== 1'b1 || fifo_din !== 6'h39) $display("FAIL flush_regrant: got id %0d busy %b din %h exp 3 1 39", grant_id, busy, fifo_din); else n_pass++;
    endtask

    task automatic test_clr_last();
        int base;
        do_reset();
        req_valid = 4'b0001;
        req_last  = 4'b0001;
        req_data  = 16'h0057;
        @(negedge clk);
        base   = enq_total;
        clr_in = 1'b1;
        #1;
        n_checks++; if (fifo_enq !== 1'b0 || fifo_clr !== 1'b1) $display("FAIL cl_collide: got enq %b clr %b exp 0 1", fifo_enq, fifo_clr); else n_pass++;
        @(negedge clk);
        clr_in    = 1'b0;
        req_valid = 4'b0011;
        req_last  = 4'b0011;
        #1;
        n_checks++; if (busy !== 1'b0 || enq_total !== base) $display("FAIL cl_idle: got busy %b enq_count %0d exp 0 %0d", busy, enq_total, base); else n_pass++;
        @(negedge clk);
        #1;
        n_checks++; if (grant_id !== 2'd1 || busy !== 1'b1 || fifo_din !== 6'h15) $display("FAIL cl_last_grant: got id %0d busy %b din %h exp 1 1 15", grant_id, busy, fifo_din); else n_pass++;
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        enq_total = 0;
        fifo_cnt  = 0;
        rst_n     = 1'b1;
        clr_in    = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        fifo_deq  = 1'b0;
        test_reset();
        test_round_robin();
        test_burst_cap();
        test_backpressure();
        test_flush();
        test_clr_last();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares one `fifo` instance among `NUM_REQ` producers. It grants the FIFO write port to one requester at a time for a bounded burst. It drives `enq`/`din`/`clr` and honours `full_n` backpressure. Each stored word is tagged with its source ID so the consumer can demultiplex. It sits between the PE-side producers and the FIFO enqueue port in the accelerator datapath.

## Interface
- `NUM_REQ`, 4: number of producers.
- `ID_WIDTH`, 2: source-ID width; must satisfy 2^ID_WIDTH ≥ NUM_REQ.
- `DATA_WIDTH`, 4: payload width per producer.
- `BURST_LEN`, 4: maximum beats per grant; must be ≥ 1.
- `BURST_CNT_WIDTH`, 2: beat-counter width; must satisfy 2^BURST_CNT_WIDTH ≥ BURST_LEN.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst_n` in 1: synchronous, active-high reset. The block resets when `rst_n`=1 at a rising edge.
- `clr_in` in 1: synchronous flush request from the controller.
- `req_valid` in NUM_REQ: per-producer beat valid.
- `req_last` in NUM_REQ: the producer's current beat ends its burst.
- `req_data` in NUM_REQ*DATA_WIDTH: producer i's data is in bits [i*DATA_WIDTH +: DATA_WIDTH].
- `req_ready` out NUM_REQ: per-producer accept; one-hot or zero.
- `fifo_din` out ID_WIDTH+DATA_WIDTH: {owner ID, data}.
- `fifo_enq` out 1: FIFO enqueue strobe.
- `fifo_full_n` in 1: FIFO not-full.
- `fifo_clr` out 1: FIFO clear.
- `grant_id` out ID_WIDTH: current owner. Meaningful only while `busy`=1.
- `busy` out 1: the state is GRANT.

## Operation
- There are two states, IDLE and GRANT.
- Registered state: `state`, `owner`, `last_grant`, and `beat_cnt`.
- IDLE:
  - If any `req_valid` bit is set, pick the first valid index scanning cyclically from `last_grant`+1 (wrapping NUM_REQ-1 → 0).
  - At the next edge, set `owner` to that index, set `last_grant` to the same index, clear `beat_cnt`, and go to GRANT.
  - If no `req_valid` bit is set, remain in IDLE.
- GRANT:
  - `req_ready[owner]` = `fifo_full_n`; all other `req_ready` bits are 0.
  - A transfer is `req_valid[owner]` & `req_ready[owner]`.
  - `fifo_enq` = transfer, with `fifo_din` = {owner, req_data[owner]} in the same cycle.
  - On a transfer with `req_last[owner]`=1, or with `beat_cnt`=BURST_LEN-1, go to IDLE. Otherwise `beat_cnt` increments on each transfer.
  - If the owner deasserts `req_valid` without `last`, the grant stays locked. Producers must finish their bursts.
- `fifo_clr` = `clr_in`, purely combinational.
- Any cycle with `clr_in`=1:
  - `fifo_enq`=0 and all `req_ready`=0.
  - Next state is IDLE and `beat_cnt` becomes 0.
  - `last_grant` is unchanged.
  - `clr_in` has priority over a simultaneous last or burst-cap transfer.
- In IDLE, `req_ready`=0 and `fifo_enq`=0. No data moves in IDLE.

## Timing
- Reset values:
  - state=IDLE, `owner`=0, `last_grant`=NUM_REQ-1 so requester 0 wins first, `beat_cnt`=0.
  - Outputs `req_ready`=0, `fifo_enq`=0, `grant_id`=0, `busy`=0.
  - `fifo_clr` follows `clr_in`, but is forced to 0 while `rst_n`=1.
- Reset mid-burst: the burst is abandoned at that edge. The FIFO keeps the beats already enqueued.
- Grant latency: `req_valid` seen in IDLE at cycle t gives GRANT at t+1. The earliest beat is at t+1.
- `req_ready` and `fifo_enq` depend combinationally on `fifo_full_n`, with no added register stage.
- There is one IDLE bubble between bursts. Peak throughput is BURST_LEN/(BURST_LEN+1) beats per cycle.
- If `fifo_full_n`=0, there is no transfer, `beat_cnt` holds, and the state holds.

## Structure
- Package `fifo_arb_pkg` holds:
  - the state encoding constants (IDLE=0, GRANT=1);
  - the default parameter values, shared with the bench.
- Sub-module `rr_pick`: combinational round-robin picker.
  - Inputs: `req` [NUM_REQ] and `last` [ID_WIDTH].
  - Outputs: `found` and `idx` [ID_WIDTH].

## Test plan
All scenarios use a `fifo` with DATA_WIDTH=6, FIFO_DEPTH=3, and default arbiter parameters.
- Reset: hold `rst_n`=1 for 2 cycles with `req_valid`=4'b1111. Required: all outputs 0 and `busy`=0. After release, the first `grant_id` is 0.
- Round robin: all producers valid, each beat has `last`=1, and data = ID+1. Required: grants 0,1,2,3,0 in alternate cycles. The FIFO receives {0,1},{1,2},{2,3} and then `full_n`=0.
- Burst cap: only producer 1 valid, `last` never set, data 1..6, consumer dequeues every cycle. Required: beats 1–4 are tagged ID 1, followed by one idle bubble, then beats 5 and 6 after regrant to ID 1.
- Backpressure: producer 0 sends a 4-beat burst with no dequeue. Required:
  - 3 enqueues, then `full_n`=0 and `req_ready`=0 while the state stays in GRANT;
  - after one dequeue, the 4th beat enqueues and the state returns to IDLE.
- Flush mid-burst: assert `clr_in` after 2 beats of producer 2. Required:
  - `fifo_clr`=1 and `fifo_enq`=0 in that cycle;
  - `empty_n`=0 next cycle;
  - the next grant goes to producer 3 if it is valid.
- Clear/last collision: `clr_in`=1 in the same cycle as a `last` beat. Required: no enqueue, state IDLE, and `last_grant` unchanged.
